dmem_cache_ctrl: RTL and testbench
==================================

Name: dmem_cache_ctrl

Overview:
- Direct-mapped, write-through data cache controller between the pipeline MEM stage and the multi-cycle backing data memory.
- Produces the data-memory stall that freezes the ID_EX and EX_MEM latches, and the read data captured by MEM_WB.
- Hits complete in the request cycle. Misses and writes go through a req/ack handshake with backing memory.
- Keeps hit/miss statistics for dump.

Parameters:
- INDEX_BITS, 5, line index width; the cache holds 2**INDEX_BITS one-word (16-bit) lines.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before flagging err.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- req_en  in  1  MEM stage access valid (DMemEn).
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  16  byte address (aluOutput).
- req_wdata  in  16  store data.
- rd_data  out  16  load data, valid when done & ~req_wr.
- done  out  1  access completes this cycle.
- stall  out  1  pipeline must hold; feeds dataMemoryStallOut.
- hit  out  1  done access was a cache hit.
- err  out  1  misaligned access or backing-memory timeout; sticky until reset.
- mem_req  out  1  backing memory request.
- mem_wr  out  1  backing write.
- mem_addr  out  16  backing address.
- mem_wdata  out  16  backing write data.
- mem_rdata  in  16  backing read data, valid with mem_ack.
- mem_ack  in  1  backing access complete, single-cycle pulse.
- hit_count  out  16  saturating load-hit count.
- miss_count  out  16  saturating load-miss count.

Behaviour:
- Address split:
  - bit0 must be 0.
  - index = addr[INDEX_BITS:1].
  - tag = addr[15:INDEX_BITS+1].
- Storage: per line, a valid bit, a tag and a 16-bit data word.
- Reset (rst==0 at a clk edge), regardless of state:
  - All valid bits clear; state IDLE.
  - err, both counters, mem_req, done, hit and stall go to 0; rd_data goes to 0.
  - An in-flight backing access is abandoned; a later mem_ack is ignored while not in a wait state.
- State IDLE:
  - req_en=0: no action; all outputs 0.
  - Misaligned (addr[0]=1): done=1, err set next cycle, no cache or memory change, stall=0.
  - Load hit (valid & tag match): rd_data = line data combinationally, done=1, hit=1, stall=0, hit_count+1.
  - Load miss: stall=1 combinationally in the same cycle. Latch addr, go to RD_WAIT, miss_count+1.
  - Store: stall=1 combinationally. Latch addr and wdata, go to WR_WAIT.
- RD_WAIT:
  - mem_req=1, mem_wr=0, mem_addr = latched addr with bit0=0; stall=1.
  - On mem_ack: fill the line (valid=1, tag, data = mem_rdata), register mem_rdata, go to RESP.
- WR_WAIT:
  - mem_req=1, mem_wr=1, mem_wdata = latched data; stall=1.
  - On mem_ack: write-allocate (valid=1, tag, data = stored word), go to RESP.
- RESP:
  - done=1, stall=0, hit=0; rd_data = registered fill data (loads).
  - Next state IDLE. A new req_en in this cycle is not sampled; the pipeline has advanced and re-presents the next access in IDLE.
- Request stability: the requester holds req_* stable while stall=1. The controller uses only latched copies after leaving IDLE.
- Timeout:
  - A wait counter clears on entry to RD_WAIT/WR_WAIT and increments each waiting cycle.
  - When it reaches TIMEOUT without ack: err=1, go to RESP with rd_data=0, no fill.
- mem_ack and timeout in the same cycle: ack wins, no err.
- Counters saturate at 16'hFFFF.
- Conflicting index: a new tag overwrites the line (no write-back needed, because the cache is write-through).
- Latency:
  - Hit: 0 stall cycles.
  - Miss or store: stall for (1 + backing latency) cycles, then one RESP cycle.

Decomposition:
- Shared package dmem_cache_pkg holds:
  - State enum {IDLE, RD_WAIT, WR_WAIT, RESP}.
  - Address field widths and extraction constants.
  - Counter saturation value.
- One sub-module, dmem_cache_array: valid/tag/data storage with a combinational read port, a synchronous write port and synchronous invalidate-all on reset.
- The FSM, counters and timeout live in the top.

Test Plan:
- Load 0x0040 cold, backing returns 0xBEEF after 3 cycles -> stall high 4 cycles, then done=1, hit=0, rd_data=0xBEEF, miss_count=1; a repeat load gives done=1, hit=1 in the same cycle, hit_count=1.
- Store 0x1234 to 0x0080, ack after 2 cycles, then load 0x0080 -> store stalls 3 cycles with mem_wr=1 and mem_wdata=0x1234; the load hits with 0x1234 and no mem_req.
- Load 0x0040 (fill 0xAAAA), then load 0x0840 (same index, different tag, fill 0x5555), then load 0x0040 -> misses on all three; the last issues mem_req; miss_count=3.
- Load 0x0041 -> done=1, no mem_req, err=1 next cycle and stays 1 until rst=0.
- Assert rst=0 during RD_WAIT, then ack arrives -> state IDLE, no fill, the next load of that address misses, counters 0.
- Never ack, TIMEOUT=255 -> stall for 256 cycles, err=1, RESP with rd_data=0, line stays invalid.

Source files
------------

// File: rtl/dmem_cache_pkg.sv
// Shared types and constants for the direct-mapped, write-through data cache.
package dmem_cache_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int WORD_OFF = 1;  // byte-offset bits below the line index

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_cache_array.sv
// Valid/tag/data line storage: combinational read, synchronous write,
// synchronous invalidate-all while rst is low.
module dmem_cache_array
  import dmem_cache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TAG_W      = ADDR_W - INDEX_BITS - WORD_OFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_data;
    end
  end

  // Only the valid bits need clearing; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped write-through data cache controller between the MEM stage
// and a multi-cycle backing memory; drives the pipeline data-memory stall.
//
//   state   | meaning
//   IDLE    | accept access; hits and misaligned accesses complete here
//   RD_WAIT | load miss, waiting for backing read ack
//   WR_WAIT | store, waiting for backing write ack
//   RESP    | single completion cycle after a backing access
module dmem_cache_ctrl
  import dmem_cache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              stall,
  output logic              hit,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - WORD_OFF;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:WORD_OFF] addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [DATA_W-1:0]        fill_q, fill_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic                     err_q, err_d;
  logic [15:0]              hit_cnt_q, hit_cnt_d;
  logic [15:0]              miss_cnt_q, miss_cnt_d;

  logic              lk_valid;
  logic [TAG_W-1:0]  lk_tag;
  logic [DATA_W-1:0] lk_data;
  logic              lk_hit;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;

  dmem_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_addr[INDEX_BITS:WORD_OFF]),
    .rd_valid (lk_valid),
    .rd_tag   (lk_tag),
    .rd_data  (lk_data),
    .wr_en    (arr_we),
    .wr_index (addr_q[INDEX_BITS:WORD_OFF]),
    .wr_tag   (addr_q[ADDR_W-1:INDEX_BITS+WORD_OFF]),
    .wr_data  (arr_wdata)
  );

  assign lk_hit = lk_valid && (lk_tag == req_addr[ADDR_W-1:INDEX_BITS+WORD_OFF]);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    tmr_d      = tmr_q;
    err_d      = err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rd_data    = '0;
    done       = 1'b0;
    stall      = 1'b0;
    hit        = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = {addr_q, 1'b0};
    mem_wdata  = wdata_q;
    arr_we     = 1'b0;
    arr_wdata  = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_en) begin
          if (req_addr[0]) begin
            done  = 1'b1;
            err_d = 1'b1;
          end else if (!req_wr && lk_hit) begin
            rd_data   = lk_data;
            done      = 1'b1;
            hit       = 1'b1;
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            stall   = 1'b1;
            addr_d  = req_addr[ADDR_W-1:WORD_OFF];
            tmr_d   = TMR_LOAD;
            if (req_wr) begin
              wdata_d = req_wdata;
              state_d = WR_WAIT;
            end else begin
              miss_cnt_d = sat_inc(miss_cnt_q);
              state_d    = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT, WR_WAIT: begin
        mem_req = 1'b1;
        mem_wr  = (state_q == WR_WAIT);
        stall   = 1'b1;
        // Ack is checked first so a last-cycle ack beats the timeout.
        if (mem_ack) begin
          arr_we    = 1'b1;
          arr_wdata = (state_q == WR_WAIT) ? wdata_q : mem_rdata;
          fill_d    = (state_q == WR_WAIT) ? '0 : mem_rdata;
          state_d   = RESP;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          fill_d  = '0;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      RESP: begin
        done    = 1'b1;
        rd_data = fill_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fill_q     <= fill_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign err        = err_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Self-checking bench for dmem_cache_ctrl: directed scenarios plus randomized
// accesses against a line-level reference model of the cache.
module tb_dmem_cache_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        req_en;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] rd_data;
  logic        done;
  logic        stall;
  logic        hit;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dmem_cache_ctrl #(.INDEX_BITS(5), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_en     (req_en),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rd_data    (rd_data),
    .done       (done),
    .stall      (stall),
    .hit        (hit),
    .err        (err),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: one entry per line, keyed by index.
  bit          m_valid [32];
  logic [9:0]  m_tag   [32];
  logic [15:0] m_data  [32];
  logic [15:0] m_hits;
  logic [15:0] m_miss;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_hits = '0;
    m_miss = '0;
    m_err  = 1'b0;
  endtask

  task automatic full_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_en = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  // lat = wait cycle (1..) in which mem_ack pulses; 0 = never ack.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int lat, input logic [15:0] rdat);
    int         idx;
    logic [9:0] tg;
    bit         mhit;
    bit         acked;
    int         wexp;
    int         n;
    bit         seen_done;
    idx  = int'(addr[5:1]);
    tg   = addr[15:6];
    mhit = !wr && !addr[0] && m_valid[idx] && (m_tag[idx] == tg);

    @(posedge clk); #1;
    req_en = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    if (addr[0]) begin
      chk("mis_done", done, 1);
      chk("mis_stall", stall, 0);
      chk("mis_memreq", mem_req, 0);
      m_err = 1'b1;
    end else if (mhit) begin
      chk("hit_done", done, 1);
      chk("hit_flag", hit, 1);
      chk("hit_data", rd_data, m_data[idx]);
      chk("hit_stall", stall, 0);
      chk("hit_memreq", mem_req, 0);
      if (m_hits != 16'hFFFF) m_hits++;
    end else begin
      chk("req_stall", stall, 1);
      chk("req_done", done, 0);
      if (!wr && m_miss != 16'hFFFF) m_miss++;
      acked = (lat >= 1) && (lat <= TIMEOUT);
      wexp  = acked ? lat : TIMEOUT;
      n = 0;
      seen_done = 1'b0;
      for (int k = 1; k <= TIMEOUT + 4 && !seen_done; k++) begin
        @(posedge clk); #1;
        mem_ack   = (k == lat);
        mem_rdata = rdat;
        @(negedge clk);
        if (done) seen_done = 1'b1;
        else if (stall && mem_req && (mem_wr == wr) && (mem_addr == addr) &&
                 (!wr || mem_wdata == wd)) n++;
      end
      chk("wait_cycles", n, wexp);
      chk("resp_done", done, 1);
      chk("resp_stall", stall, 0);
      chk("resp_hit", hit, 0);
      if (!wr) chk("resp_data", rd_data, acked ? rdat : 16'h0000);
      if (acked) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = wr ? wd : rdat;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    req_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("err", err, m_err);
    chk("hit_cnt", hit_count, m_hits);
    chk("miss_cnt", miss_count, m_miss);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    rst = 1'b0; req_en = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", err, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_rddata", rd_data, 0);
    chk("rst_hitcnt", hit_count, 0);
    chk("rst_misscnt", miss_count, 0);

    // cold load miss then hit
    access(0, 16'h0040, 16'h0000, 3, 16'hBEEF);
    access(0, 16'h0040, 16'h0000, 1, 16'h0000);
    chk("plan1_hits", hit_count, 1);

    // store then load hit of stored word
    access(1, 16'h0080, 16'h1234, 2, 16'h0000);
    access(0, 16'h0080, 16'h0000, 1, 16'h0000);

    // conflicting tags on the same index
    full_reset();
    access(0, 16'h0040, 16'h0000, 2, 16'hAAAA);
    access(0, 16'h0840, 16'h0000, 2, 16'h5555);
    access(0, 16'h0040, 16'h0000, 1, 16'hAAAA);
    chk("plan3_misses", miss_count, 3);

    // randomized accesses over a small set of lines and tags
    for (int i = 0; i < 40; i++) begin
      a = 16'((($urandom_range(0, 2)) << 6) | (($urandom_range(0, 3)) << 1));
      access(($urandom_range(0, 3) == 0), a, 16'($urandom), $urandom_range(1, 4), 16'($urandom));
    end

    // misaligned access: err is sticky until reset
    access(0, 16'h0041, 16'h0000, 1, 16'h0000);
    access(0, 16'h0040, 16'h0000, 2, 16'h3C3C);
    chk("err_sticky", err, 1);
    full_reset();
    @(negedge clk);
    chk("err_cleared", err, 0);

    // reset during RD_WAIT, late ack ignored
    @(posedge clk); #1;
    req_en = 1'b1; req_wr = 1'b0; req_addr = 16'h0200; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("prerst_memreq", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b0; req_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    model_clear();
    @(negedge clk);
    chk("rstw_stall", stall, 0);
    chk("rstw_memreq", mem_req, 0);
    chk("rstw_done", done, 0);
    chk("rstw_hitcnt", hit_count, 0);
    chk("rstw_misscnt", miss_count, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    access(0, 16'h0200, 16'h0000, 2, 16'h1111);
    chk("rstw_refill_miss", miss_count, 1);

    // timeout with no ack, line must remain invalid
    access(0, 16'h0100, 16'h0000, 0, 16'h0000);
    access(0, 16'h0100, 16'h0000, 1, 16'h7777);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
